seq_ldidx: RTL and testbench

SEQ_LDIDX -- requirements
Module: seq_ldidx

---
 rtl/seq_ldidx.sv | 216 +++++++++++++++++++++
 tb/tb_seq_ldidx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_ldidx.sv
// Sequencer for Z80-style indexed loads/stores: LD r,(IX/IY+d) and LD (IX/IY+d),r.
// Define SEQ_LDIDX_TSTATE_DELAY_EN to stretch the address phase to 5 cycles.
module seq_ldidx (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic        is_Y,
    input  logic        is_store,
    input  logic [2:0]  reg_sel,
    input  logic [15:0] IX,
    input  logic [15:0] IY,
    input  logic [15:0] PC,
    input  logic [7:0]  reg_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        pc_inc,
    output logic        busy,
    output logic        done,
    output logic        wb_en,
    output logic [2:0]  wb_sel,
    output logic [7:0]  wb_data,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DISP = 3'd1,
        S_ADDR = 3'd2,
        S_MEM  = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] base_q, base_d;
    logic        store_q, store_d;
    logic [2:0]  sel_q, sel_d;
    logic [7:0]  rdat_q, rdat_d;
    logic [7:0]  disp_q, disp_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        wb_en_q, wb_en_d;
    logic [7:0]  wb_data_q, wb_data_d;
    logic        err_q, err_d;
    logic [15:0] ea_s;
    logic        go_mem_s;
`ifdef SEQ_LDIDX_TSTATE_DELAY_EN
    logic [2:0]  cnt_q, cnt_d;
`endif

    // Next-state and next-output computation for the whole sequencer.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        store_d     = store_q;
        sel_d       = sel_q;
        rdat_d      = rdat_q;
        disp_d      = disp_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wb_data_d   = wb_data_q;
        done_d      = 1'b0;
        wb_en_d     = 1'b0;
        err_d       = 1'b0;
        go_mem_s    = 1'b0;
`ifdef SEQ_LDIDX_TSTATE_DELAY_EN
        cnt_d       = cnt_q;
`endif
        // Displacement is signed; the 16-bit sum wraps silently.
        ea_s = base_q + {{8{disp_q[7]}}, disp_q};

        case (state_q)
            S_IDLE: begin
                if (start && (reg_sel == 3'b110)) begin
                    err_d = 1'b1;
                end else if (start) begin
                    base_d      = is_Y ? IY : IX;
                    store_d     = is_store;
                    sel_d       = reg_sel;
                    rdat_d      = reg_data;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = PC;
                    mem_wdata_d = 8'h00;
                    state_d     = S_DISP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DISP: begin
                if (mem_ack) begin
                    disp_d    = mem_rdata;
                    mem_req_d = 1'b0;
                    state_d   = S_ADDR;
`ifdef SEQ_LDIDX_TSTATE_DELAY_EN
                    cnt_d     = 3'd0;
`endif
                end else begin
                    state_d = S_DISP;
                end
            end
            S_ADDR: begin
`ifdef SEQ_LDIDX_TSTATE_DELAY_EN
                if (cnt_q == 3'd4) begin
                    go_mem_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
`else
                go_mem_s = 1'b1;
`endif
                if (go_mem_s) begin
                    mem_req_d   = 1'b1;
                    mem_addr_d  = ea_s;
                    mem_we_d    = store_q;
                    mem_wdata_d = store_q ? rdat_q : 8'h00;
                    state_d     = S_MEM;
                end else begin
                    state_d = S_ADDR;
                end
            end
            S_MEM: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    done_d    = 1'b1;
                    wb_en_d   = ~store_q;
                    state_d   = S_FIN;
                    if (!store_q) begin
                        wb_data_d = mem_rdata;
                    end else begin
                        wb_data_d = wb_data_q;
                    end
                end else begin
                    state_d = S_MEM;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and registered-output flops with asynchronous reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            base_q      <= 16'h0000;
            store_q     <= 1'b0;
            sel_q       <= 3'b000;
            rdat_q      <= 8'h00;
            disp_q      <= 8'h00;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 8'h00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wb_en_q     <= 1'b0;
            wb_data_q   <= 8'h00;
            err_q       <= 1'b0;
`ifdef SEQ_LDIDX_TSTATE_DELAY_EN
            cnt_q       <= 3'd0;
`endif
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            store_q     <= store_d;
            sel_q       <= sel_d;
            rdat_q      <= rdat_d;
            disp_q      <= disp_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            wb_en_q     <= wb_en_d;
            wb_data_q   <= wb_data_d;
            err_q       <= err_d;
`ifdef SEQ_LDIDX_TSTATE_DELAY_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    // pc_inc must coincide with the displacement ack, so it is decoded from registered state.
    assign pc_inc    = (state_q == S_DISP) && mem_req_q && mem_ack;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign wb_en     = wb_en_q;
    assign wb_sel    = sel_q;
    assign wb_data   = wb_data_q;
    assign err       = err_q;

endmodule

// File: tb/tb_seq_ldidx.sv
// Scoreboard bench for seq_ldidx: directed ops push expectations, a monitor pops on done/err.
module tb_seq_ldidx;

`ifdef SEQ_LDIDX_TSTATE_DELAY_EN
    localparam int LAT = 8;
`else
    localparam int LAT = 4;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0, is_Y = 1'b0, is_store = 1'b0;
    logic [2:0]  reg_sel = 3'b000;
    logic [15:0] IX = 16'h0000, IY = 16'h0000, PC = 16'h0000;
    logic [7:0]  reg_data = 8'h00, mem_rdata = 8'h00;
    logic        mem_ack = 1'b0;
    logic        mem_req, mem_we, pc_inc, busy, done, wb_en, err;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, wb_data;
    logic [2:0]  wb_sel;

    seq_ldidx dut (
        .CLK(CLK), .RST(RST), .start(start), .is_Y(is_Y), .is_store(is_store),
        .reg_sel(reg_sel), .IX(IX), .IY(IY), .PC(PC), .reg_data(reg_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .pc_inc(pc_inc), .busy(busy),
        .done(done), .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data), .err(err)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic        is_err;
        logic [15:0] ea;
        logic        we;
        logic [7:0]  wdata;
        logic        wb_en;
        logic [2:0]  wb_sel;
        logic [7:0]  wb_data;
        int          lat;
        int          t0;
    } exp_t;
    exp_t exp_q[$];

    logic [7:0]  rsp_d = 8'h00, rsp_ld = 8'h00;
    int          rsp_wait = 0;
    int          rcnt = 0;
    logic        ph;
    logic [15:0] cap_addr = 16'h0000, prev_addr = 16'h0000;
    logic        cap_we = 1'b0, prev_req = 1'b0, prev_we = 1'b0;
    logic [7:0]  cap_wdata = 8'h00;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    always @(posedge CLK or posedge RST) begin
        if (RST) ph <= 1'b0;
        else if (mem_req && mem_ack) ph <= ~ph;
    end

    // Capture data-phase transaction and check pc_inc at each ack edge.
    always @(posedge CLK) begin
        if (!RST && mem_req && mem_ack) begin
            if (ph == 1'b0) begin
                chk("pc_inc_on_disp_ack", {31'd0, pc_inc}, 32'd1);
            end else begin
                cap_addr  = mem_addr;
                cap_we    = mem_we;
                cap_wdata = mem_wdata;
                chk("pc_inc_in_mem", {31'd0, pc_inc}, 32'd0);
            end
        end else if (pc_inc === 1'b1) begin
            chk("pc_inc_spurious", {31'd0, pc_inc}, 32'd0);
        end
    end

    // Memory responder, stability checker and scoreboard monitor.
    always @(negedge CLK) begin
        exp_t e;
        if (mem_req && !RST) begin
            mem_ack   = (rcnt >= (ph ? rsp_wait : 0));
            mem_rdata = ph ? rsp_ld : rsp_d;
            rcnt++;
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = 8'h00;
            rcnt      = 0;
        end
        if (mem_req && prev_req) begin
            chk("addr_stable", {16'd0, mem_addr}, {16'd0, prev_addr});
            chk("we_stable", {31'd0, mem_we}, {31'd0, prev_we});
        end
        prev_req  = mem_req;
        prev_addr = mem_addr;
        prev_we   = mem_we;
        if (done || err) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done_err", {30'd0, done, err}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("latency", cyc - e.t0, e.lat);
                if (e.is_err) begin
                    chk("err_pulse", {31'd0, err}, 32'd1);
                    chk("err_no_done", {31'd0, done}, 32'd0);
                end else begin
                    chk("done", {31'd0, done}, 32'd1);
                    chk("ea", {16'd0, cap_addr}, {16'd0, e.ea});
                    chk("we", {31'd0, cap_we}, {31'd0, e.we});
                    chk("wdata", {24'd0, cap_wdata}, {24'd0, e.wdata});
                    chk("wb_en", {31'd0, wb_en}, {31'd0, e.wb_en});
                    chk("wb_sel", {29'd0, wb_sel}, {29'd0, e.wb_sel});
                    if (e.wb_en) chk("wb_data", {24'd0, wb_data}, {24'd0, e.wb_data});
                end
            end
        end
    end

    task automatic issue(input bit y, input bit st, input bit [2:0] sel, input bit [15:0] base,
                         input bit [15:0] pc, input bit [7:0] rd, input bit [7:0] d,
                         input bit [7:0] ld, input int w, input bit [15:0] ea_exp);
        exp_t e;
        @(negedge CLK);
        is_Y = y; is_store = st; reg_sel = sel; PC = pc; reg_data = rd;
        IX = y ? 16'h0BAD : base;
        IY = y ? base : 16'h0BAD;
        rsp_d = d; rsp_ld = ld; rsp_wait = w;
        e.is_err  = (sel == 3'b110);
        e.ea      = ea_exp;
        e.we      = st;
        e.wdata   = st ? rd : 8'h00;
        e.wb_en   = ~st;
        e.wb_sel  = sel;
        e.wb_data = ld;
        e.lat     = e.is_err ? 1 : LAT + w;
        e.t0      = cyc;
        exp_q.push_back(e);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 60 && (exp_q.size() != 0 || busy); i++) begin
            @(negedge CLK);
            #1;
        end
        chk("drain_queue", exp_q.size(), 0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_req"}, {31'd0, mem_req}, 32'd0);
        chk({nm, "_we"}, {31'd0, mem_we}, 32'd0);
        chk({nm, "_addr"}, {16'd0, mem_addr}, 32'd0);
        chk({nm, "_wdata"}, {24'd0, mem_wdata}, 32'd0);
        chk({nm, "_flags"}, {27'd0, pc_inc, busy, done, wb_en, err}, 32'd0);
        chk({nm, "_wb"}, {21'd0, wb_sel, wb_data}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        #1;
        chk_all_zero("reset");
        RST = 1'b0;

        // IX=0x1000,d=0x05 load A -> 0x1005, wb 0x5A
        issue(1'b0, 1'b0, 3'b111, 16'h1000, 16'h0100, 8'h00, 8'h05, 8'h5A, 0, 16'h1005);
        wait_idle();
        // IY=0x2000,d=0xFE store 0xC3 -> 0x1FFE
        issue(1'b1, 1'b1, 3'b000, 16'h2000, 16'h0200, 8'hC3, 8'hFE, 8'h00, 0, 16'h1FFE);
        wait_idle();
        // wrap: 0xFFFF+1 -> 0x0000, load B
        issue(1'b0, 1'b0, 3'b000, 16'hFFFF, 16'h0300, 8'h00, 8'h01, 8'h33, 0, 16'h0000);
        wait_idle();
        // 0x0000 + (-128) -> 0xFF80, store D
        issue(1'b0, 1'b1, 3'b010, 16'h0000, 16'h0400, 8'h7E, 8'h80, 8'h00, 0, 16'hFF80);
        wait_idle();

        // 3-cycle ack delay in MEM; starts during busy must be ignored
        issue(1'b0, 1'b0, 3'b011, 16'h3000, 16'h0500, 8'h00, 8'h10, 8'hA5, 3, 16'h3010);
        @(negedge CLK);
        IX = 16'hDEAD; reg_sel = 3'b001; start = 1'b1;
        @(negedge CLK);
        reg_sel = 3'b110;
        @(negedge CLK);
        start = 1'b0;
        wait_idle();
        repeat (4) @(negedge CLK);
        #1;
        chk("no_queued_start", {31'd0, busy}, 32'd0);

        // illegal register code: err pulse, no memory traffic
        issue(1'b0, 1'b0, 3'b110, 16'h1234, 16'h0600, 8'h00, 8'h00, 8'h00, 0, 16'h0000);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("err_no_req", {30'd0, mem_req, busy}, 32'd0);
            @(negedge CLK);
        end
        wait_idle();

        // reset while stalled in MEM
        issue(1'b1, 1'b0, 3'b101, 16'h4000, 16'h0700, 8'h00, 8'h04, 8'h99, 20, 16'h4004);
        for (int k = 0; k < 30 && !(mem_req && ph); k++) @(negedge CLK);
        chk("reached_mem", {30'd0, mem_req, ph}, 32'd3);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk_all_zero("mid_reset");
        exp_q.delete();
        repeat (3) @(negedge CLK);
        RST = 1'b0;

        // fresh op after reset
        issue(1'b1, 1'b0, 3'b100, 16'h8000, 16'h0800, 8'h00, 8'h7F, 8'h42, 0, 16'h807F);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
